// File: rtl/ram_loader.sv
// Serial program loader: parses framed byte-stream load commands and writes 32-bit
// words into RAM through the stall-write port, then pulses the CPU reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | hunting for 0xA5, discarding other bytes
// ADDR_H    | waiting for start address high byte
// ADDR_L    | waiting for start address low byte
// CNT_H     | waiting for word count high byte
// CNT_L     | waiting for word count low byte
// DATA      | shifting data bytes into the word register, MSB first
// WRITE     | one-cycle RAM write strobe, no byte accepted
// CSUM      | waiting for checksum byte
// RELEASE   | holding cpu_rst_o with the CPU still stalled
module ram_loader #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned RST_CYCLES     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              openRISC_STALL,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [31:0]       RAM_DATA_O,
   output logic              cpu_rst_o,
   output logic              load_done_o,
   output logic              load_err_o
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned REL_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_CNT_H,
      S_CNT_L,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_RELEASE
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          addr_hi_q, addr_hi_d;
   logic [7:0]          cnt_hi_q, cnt_hi_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [1:0]          idx_q, idx_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [REL_W-1:0]    rel_q, rel_d;
   logic                ready_d, stall_d, we_d, cpu_rst_d, done_d, err_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [31:0]         data_d;
   logic                hs;
   logic                timing;
   logic                timed_out;

   assign hs = rx_valid_i & rx_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         addr_hi_q      <= '0;
         cnt_hi_q       <= '0;
         cnt_q          <= '0;
         idx_q          <= '0;
         csum_q         <= '0;
         tmr_q          <= '0;
         rel_q          <= '0;
         rx_ready_o     <= 1'b0;
         openRISC_STALL <= 1'b0;
         RAM_WE         <= 1'b0;
         RAM_ADDR       <= '0;
         RAM_DATA_O     <= '0;
         cpu_rst_o      <= 1'b0;
         load_done_o    <= 1'b0;
         load_err_o     <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_hi_q      <= addr_hi_d;
         cnt_hi_q       <= cnt_hi_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         csum_q         <= csum_d;
         tmr_q          <= tmr_d;
         rel_q          <= rel_d;
         rx_ready_o     <= ready_d;
         openRISC_STALL <= stall_d;
         RAM_WE         <= we_d;
         RAM_ADDR       <= addr_d;
         RAM_DATA_O     <= data_d;
         cpu_rst_o      <= cpu_rst_d;
         load_done_o    <= done_d;
         load_err_o     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_hi_d = addr_hi_q;
      cnt_hi_d  = cnt_hi_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      tmr_d     = tmr_q;
      rel_d     = rel_q;
      stall_d   = openRISC_STALL;
      we_d      = 1'b0;
      addr_d    = RAM_ADDR;
      data_d    = RAM_DATA_O;
      done_d    = 1'b0;
      err_d     = load_err_o;

      // Inter-byte timer: reloaded on every accepted byte, fires on its last cycle
      timing    = (state_q != S_IDLE) && (state_q != S_RELEASE);
      timed_out = timing && !hs && (tmr_q <= TMR_W'(1));
      if (hs) begin
         tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
      end else if (timing && (tmr_q != '0)) begin
         tmr_d = tmr_q - TMR_W'(1);
      end

      if (hs && (state_q inside {S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA})) begin
         csum_d = csum_q ^ rx_data_i;
      end

      case (state_q)
         S_IDLE: begin
            if (hs && (rx_data_i == 8'hA5)) begin
               state_d = S_ADDR_H;
               stall_d = 1'b1;
               err_d   = 1'b0;
               csum_d  = 8'h00;
            end
         end
         S_ADDR_H: begin
            if (hs) begin
               addr_hi_d = rx_data_i;
               state_d   = S_ADDR_L;
            end
         end
         S_ADDR_L: begin
            if (hs) begin
               addr_d  = ADDR_W'({addr_hi_q, rx_data_i});
               state_d = S_CNT_H;
            end
         end
         S_CNT_H: begin
            if (hs) begin
               cnt_hi_d = rx_data_i;
               state_d  = S_CNT_L;
            end
         end
         S_CNT_L: begin
            if (hs) begin
               cnt_d   = {cnt_hi_q, rx_data_i};
               idx_d   = 2'd0;
               state_d = ({cnt_hi_q, rx_data_i} == 16'h0000) ? S_CSUM : S_DATA;
            end
         end
         S_DATA: begin
            if (hs) begin
               data_d = {RAM_DATA_O[23:0], rx_data_i};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_WRITE;
                  we_d    = 1'b1;
               end
            end
         end
         S_WRITE: begin
            addr_d  = RAM_ADDR + ADDR_W'(1);
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (hs) begin
               if (rx_data_i == csum_q) begin
                  state_d = S_RELEASE;
                  rel_d   = REL_W'(RST_CYCLES - 1);
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         S_RELEASE: begin
            if (rel_q == '0) begin
               state_d = S_IDLE;
               stall_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               rel_d = rel_q - REL_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort keeps the stall so a half-written image never runs
      if (timed_out) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         we_d    = 1'b0;
      end

      cpu_rst_d = (state_d == S_RELEASE);
      ready_d   = (state_d != S_WRITE) && (state_d != S_RELEASE);
   end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frame loads, checksum errors, wrap, timeout, noise and reset.
module tb_ram_loader;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic        openRISC_STALL;
   logic        RAM_WE;
   logic [15:0] RAM_ADDR;
   logic [31:0] RAM_DATA_O;
   logic        cpu_rst_o;
   logic        load_done_o;
   logic        load_err_o;

   always #5 clk = ~clk;

   ram_loader #(.ADDR_W(16), .TIMEOUT_CYCLES(100), .RST_CYCLES(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .rx_data_i      (rx_data_i),
      .rx_valid_i     (rx_valid_i),
      .rx_ready_o     (rx_ready_o),
      .openRISC_STALL (openRISC_STALL),
      .RAM_WE         (RAM_WE),
      .RAM_ADDR       (RAM_ADDR),
      .RAM_DATA_O     (RAM_DATA_O),
      .cpu_rst_o      (cpu_rst_o),
      .load_done_o    (load_done_o),
      .load_err_o     (load_err_o)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          rst_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          stall_rise_cyc = -1;
   int          err_rise_cyc = -1;
   logic [7:0]  frame[$];
   int          hs_cyc[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : monitor
      logic prev_stall;
      logic prev_err;
      prev_stall = 1'b0;
      prev_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (RAM_WE === 1'b1) begin
            wr_addr.push_back(RAM_ADDR);
            wr_data.push_back(RAM_DATA_O);
            wr_cyc.push_back(cyc);
         end
         if (cpu_rst_o === 1'b1) rst_cnt++;
         if (load_done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (openRISC_STALL === 1'b1 && !prev_stall) stall_rise_cyc = cyc;
         if (load_err_o === 1'b1 && !prev_err) err_rise_cyc = cyc;
         prev_stall = (openRISC_STALL === 1'b1);
         prev_err   = (load_err_o === 1'b1);
      end
   end

   task automatic send_frame();
      int guard;
      hs_cyc.delete();
      foreach (frame[i]) begin
         @(negedge clk);
         rx_valid_i = 1'b1;
         rx_data_i  = frame[i];
         guard = 0;
         while (rx_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL handshake byte %0d: ready never seen, got %b required 1", i, rx_ready_o);
         end
         hs_cyc.push_back(cyc);
      end
      @(negedge clk);
      rx_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_i      = 1'b1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      tests++;
      if ({rx_ready_o, openRISC_STALL, RAM_WE, RAM_ADDR, RAM_DATA_O, cpu_rst_o, load_done_o, load_err_o} !== 54'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h required 0",
                  {rx_ready_o, openRISC_STALL, RAM_WE, RAM_ADDR, RAM_DATA_O, cpu_rst_o, load_done_o, load_err_o});
      end
      rst_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rx_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_rise: got %b required 1", rx_ready_o);
      end
   endtask

   task automatic test_good_load(input bit check_stall_rise);
      int w0, r0, d0;
      w0 = wr_addr.size();
      r0 = rst_cnt;
      d0 = done_cnt;
      frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
      send_frame();
      wait_done(d0);
      if (check_stall_rise) begin
         tests++;
         if (stall_rise_cyc !== hs_cyc[0] + 1) begin
            fails++;
            $display("FAIL good_stall_latency: got %0d required %0d", stall_rise_cyc, hs_cyc[0] + 1);
         end
      end
      tests++;
      if (wr_addr.size() - w0 !== 2) begin
         fails++;
         $display("FAIL good_write_count: got %0d required 2", wr_addr.size() - w0);
      end
      if (wr_addr.size() >= w0 + 2) begin
         tests++;
         if (wr_addr[w0] !== 16'h0010 || wr_data[w0] !== 32'h11223344) begin
            fails++;
            $display("FAIL good_write0: got %h@%h required 11223344@0010", wr_data[w0], wr_addr[w0]);
         end
         tests++;
         if (wr_addr[w0+1] !== 16'h0011 || wr_data[w0+1] !== 32'h55667788) begin
            fails++;
            $display("FAIL good_write1: got %h@%h required 55667788@0011", wr_data[w0+1], wr_addr[w0+1]);
         end
         tests++;
         if (wr_cyc[w0] !== hs_cyc[8] + 1) begin
            fails++;
            $display("FAIL good_write_latency: got %0d required %0d", wr_cyc[w0], hs_cyc[8] + 1);
         end
      end
      tests++;
      if (rst_cnt - r0 !== 16) begin
         fails++;
         $display("FAIL good_cpu_rst_len: got %0d required 16", rst_cnt - r0);
      end
      tests++;
      if (done_cnt - d0 !== 1) begin
         fails++;
         $display("FAIL good_done_pulses: got %0d required 1", done_cnt - d0);
      end
      tests++;
      if (done_cyc !== hs_cyc[13] + 17) begin
         fails++;
         $display("FAIL good_done_latency: got %0d required %0d", done_cyc, hs_cyc[13] + 17);
      end
      tests++;
      if (openRISC_STALL !== 1'b0 || load_err_o !== 1'b0) begin
         fails++;
         $display("FAIL good_final_stall_err: got %b%b required 00", openRISC_STALL, load_err_o);
      end
   endtask

   task automatic test_bad_csum();
      int w0, r0, d0;
      w0 = wr_addr.size();
      r0 = rst_cnt;
      d0 = done_cnt;
      frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h9B};
      send_frame();
      repeat (30) @(negedge clk);
      tests++;
      if (wr_addr.size() - w0 !== 2) begin
         fails++;
         $display("FAIL bad_write_count: got %0d required 2", wr_addr.size() - w0);
      end
      tests++;
      if (load_err_o !== 1'b1 || openRISC_STALL !== 1'b1) begin
         fails++;
         $display("FAIL bad_err_stall: got err=%b stall=%b required err=1 stall=1", load_err_o, openRISC_STALL);
      end
      tests++;
      if (rst_cnt - r0 !== 0 || done_cnt - d0 !== 0) begin
         fails++;
         $display("FAIL bad_no_release: got rst=%0d done=%0d required 0 0", rst_cnt - r0, done_cnt - d0);
      end
      test_good_load(1'b0);
   endtask

   task automatic test_empty();
      int w0, r0, d0;
      w0 = wr_addr.size();
      r0 = rst_cnt;
      d0 = done_cnt;
      frame = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
      send_frame();
      wait_done(d0);
      tests++;
      if (wr_addr.size() - w0 !== 0) begin
         fails++;
         $display("FAIL empty_no_write: got %0d required 0", wr_addr.size() - w0);
      end
      tests++;
      if (rst_cnt - r0 !== 16 || done_cnt - d0 !== 1) begin
         fails++;
         $display("FAIL empty_release: got rst=%0d done=%0d required 16 1", rst_cnt - r0, done_cnt - d0);
      end
      tests++;
      if (done_cyc !== hs_cyc[5] + 17) begin
         fails++;
         $display("FAIL empty_done_latency: got %0d required %0d", done_cyc, hs_cyc[5] + 17);
      end
   endtask

   task automatic test_wrap();
      int w0, d0;
      w0 = wr_addr.size();
      d0 = done_cnt;
      frame = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      send_frame();
      wait_done(d0);
      tests++;
      if (wr_addr.size() - w0 !== 2) begin
         fails++;
         $display("FAIL wrap_write_count: got %0d required 2", wr_addr.size() - w0);
      end
      if (wr_addr.size() >= w0 + 2) begin
         tests++;
         if (wr_addr[w0] !== 16'hFFFF || wr_data[w0] !== 32'h01020304) begin
            fails++;
            $display("FAIL wrap_write0: got %h@%h required 01020304@ffff", wr_data[w0], wr_addr[w0]);
         end
         tests++;
         if (wr_addr[w0+1] !== 16'h0000 || wr_data[w0+1] !== 32'h05060708) begin
            fails++;
            $display("FAIL wrap_write1: got %h@%h required 05060708@0000", wr_data[w0+1], wr_addr[w0+1]);
         end
      end
      tests++;
      if (done_cnt - d0 !== 1 || load_err_o !== 1'b0) begin
         fails++;
         $display("FAIL wrap_done_err: got done=%0d err=%b required 1 0", done_cnt - d0, load_err_o);
      end
   endtask

   task automatic test_timeout();
      int w0, n;
      w0 = wr_addr.size();
      err_rise_cyc = -1;
      frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hDE, 8'hAD};
      send_frame();
      n = 0;
      while (err_rise_cyc == -1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      tests++;
      if (err_rise_cyc !== hs_cyc[6] + 100) begin
         fails++;
         $display("FAIL timeout_latency: got %0d required %0d", err_rise_cyc, hs_cyc[6] + 100);
      end
      tests++;
      if (wr_addr.size() - w0 !== 0) begin
         fails++;
         $display("FAIL timeout_no_write: got %0d required 0", wr_addr.size() - w0);
      end
      tests++;
      if (openRISC_STALL !== 1'b1 || load_err_o !== 1'b1 || rx_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL timeout_state: got stall=%b err=%b ready=%b required 1 1 1",
                  openRISC_STALL, load_err_o, rx_ready_o);
      end
   endtask

   task automatic test_noise_reset();
      int w0, d0;
      w0 = wr_addr.size();
      frame = '{8'h00, 8'hFF, 8'h5A};
      send_frame();
      repeat (3) @(negedge clk);
      tests++;
      if (openRISC_STALL !== 1'b1 || load_err_o !== 1'b1 || rx_ready_o !== 1'b1 || wr_addr.size() != w0) begin
         fails++;
         $display("FAIL noise_ignored: got stall=%b err=%b ready=%b writes=%0d required 1 1 1 0",
                  openRISC_STALL, load_err_o, rx_ready_o, wr_addr.size() - w0);
      end
      frame = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h01, 8'h02};
      send_frame();
      tests++;
      if (load_err_o !== 1'b0 || openRISC_STALL !== 1'b1) begin
         fails++;
         $display("FAIL header_clears_err: got err=%b stall=%b required 0 1", load_err_o, openRISC_STALL);
      end
      rst_i = 1'b1;
      @(negedge clk);
      tests++;
      if ({rx_ready_o, openRISC_STALL, RAM_WE, RAM_ADDR, RAM_DATA_O, cpu_rst_o, load_done_o, load_err_o} !== 54'd0) begin
         fails++;
         $display("FAIL midframe_reset: got %h required 0",
                  {rx_ready_o, openRISC_STALL, RAM_WE, RAM_ADDR, RAM_DATA_O, cpu_rst_o, load_done_o, load_err_o});
      end
      rst_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rx_ready_o !== 1'b1 || openRISC_STALL !== 1'b0) begin
         fails++;
         $display("FAIL after_reset: got ready=%b stall=%b required 1 0", rx_ready_o, openRISC_STALL);
      end
      d0 = done_cnt;
      frame = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
      send_frame();
      wait_done(d0);
      tests++;
      if (done_cnt - d0 !== 1 || wr_addr.size() != w0) begin
         fails++;
         $display("FAIL reload_after_reset: got done=%0d writes=%0d required 1 0",
                  done_cnt - d0, wr_addr.size() - w0);
      end
   endtask

   initial begin
      rst_i      = 1'b1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      test_reset();
      test_good_load(1'b1);
      test_bad_csum();
      test_empty();
      test_wrap();
      test_timeout();
      test_noise_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
